// File: rtl/t05_sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, requester indices
// and timeout defaults.
package t05_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam int unsigned REQ_HIST        = 0;
  localparam int unsigned REQ_HTREE       = 1;
  localparam int unsigned REQ_CB          = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/t05_rr_pick.sv
// Combinational round-robin picker: first set request after last_winner, wrapping.
module t05_rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    for (int unsigned s = 1; s <= NREQ; s++) begin
      w_cand = IW'((int'(i_last) + int'(s)) % int'(NREQ));
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters a single SRAM port, with
// lock-based back-to-back bursts and a bounded wait for the SRAM completion.
module t05_sram_arbiter
  import t05_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ*4-1:0] sel,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  output logic [3:0]        bus_sel,
  input  logic              bus_done,
  input  logic [DW-1:0]     bus_rdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_owner;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_ack;
  logic             r_err;
  logic [DW-1:0]    r_rdata;
  logic             r_busy;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [AW-1:0]    r_bus_addr;
  logic [DW-1:0]    r_bus_wdata;
  logic [3:0]       r_bus_sel;
  logic [CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]  w_win_oh;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_vld;
  logic [IW-1:0]    w_lat_idx;
  logic             w_lat_we;
  logic [AW-1:0]    w_lat_addr;
  logic [DW-1:0]    w_lat_wdata;
  logic [3:0]       w_lat_sel;

  t05_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_vld)
  );

  // Payload source: the fresh winner from IDLE, the current owner on a locked re-issue.
  always_comb begin
    w_lat_idx   = (r_state == StIdle) ? w_win_idx : r_owner;
    w_lat_we    = we[w_lat_idx];
    w_lat_addr  = addr[int'(w_lat_idx) * AW +: AW];
    w_lat_wdata = wdata[int'(w_lat_idx) * DW +: DW];
    w_lat_sel   = sel[int'(w_lat_idx) * 4 +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_last      <= IW'(NREQ - 1);
      r_owner     <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_sel   <= '0;
      r_cnt       <= '0;
    end else begin
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_bus_req <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_win_vld) begin
            r_owner     <= w_win_idx;
            r_last      <= w_win_idx;
            r_grant     <= w_win_oh;
            r_bus_we    <= w_lat_we;
            r_bus_addr  <= w_lat_addr;
            r_bus_wdata <= w_lat_wdata;
            r_bus_sel   <= w_lat_sel;
            r_bus_req   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (bus_done) begin
            r_rdata <= bus_rdata;
            r_ack   <= r_grant;
            r_state <= StDone;
          end else if (r_cnt == TmoLast) begin
            r_rdata <= '0;
            r_ack   <= r_grant;
            r_err   <= 1'b1;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          if (lock[r_owner] && req[r_owner]) begin
            r_bus_we    <= w_lat_we;
            r_bus_addr  <= w_lat_addr;
            r_bus_wdata <= w_lat_wdata;
            r_bus_sel   <= w_lat_sel;
            r_bus_req   <= 1'b1;
            r_state     <= StIssue;
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant     = r_grant;
  assign ack       = r_ack;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_sel   = r_bus_sel;

endmodule
